// File: rtl/hs_mem_bridge.sv
`timescale 1ns/1ps
// hs_mem_bridge: decodes one request/acknowledge port into NREG memory regions.
// Each transaction is latched at its start edge, strobes one region, and returns a
// registered acknowledge with read data or an error flag for an unmatched address.
module hs_mem_bridge #(
    parameter int unsigned NREG       = 4,
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 8,
    parameter int unsigned SELW       = 4,
    // Region i tag lives at REG_TAG[i*SELW+:SELW]: region 0 = C, 1 = D, 2 = E, 3 = F.
    parameter logic [NREG*SELW-1:0] REG_TAG = 16'hFEDC,
    parameter int unsigned RD_LAT     = 1,
    parameter bit          NEED_PAUSE = 1'b1
) (
    input  logic               CLK40M,
    input  logic               RESET_N,
    input  logic               PAUSE_N,
    input  logic               HS_REQ,
    input  logic               HS_WE,
    input  logic [AW-1:0]      HS_AD,
    input  logic [DW-1:0]      HS_DI,
    output logic               HS_ACK,
    output logic [DW-1:0]      HS_DO,
    output logic               HS_ERR,
    output logic [NREG-1:0]    RG_CS,
    output logic [NREG-1:0]    RG_WE,
    output logic [AW-1:0]      RG_AD,
    output logic [DW-1:0]      RG_DI,
    input  logic [NREG*DW-1:0] RG_DO
);

    localparam int unsigned IW       = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [2:0]  LAT_LOAD = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRd, StDone} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   ad_q, ad_d;
    logic [DW-1:0]   di_q, di_d;
    logic            we_q, we_d;
    logic            hit_q, hit_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [DW-1:0]   do_q, do_d;

    logic            dec_hit;
    logic [IW-1:0]   dec_idx;
    logic [DW-1:0]   rd_sel;
    logic            start;

    // Only the start condition is gated by the pause; a running transaction always finishes.
    assign start = HS_REQ && (!NEED_PAUSE || !PAUSE_N);

    // Region decode on the live address; scanning downwards lets the lowest index win.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if (HS_AD[AW-1-:SELW] == REG_TAG[i*SELW+:SELW]) begin
                dec_hit = 1'b1;
                dec_idx = IW'(i);
            end
        end
    end

    // Read data of the latched region.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (sel_q == IW'(i)) begin
                rd_sel = RG_DO[i*DW+:DW];
            end
        end
    end

    // Transaction FSM next-state and datapath capture.
    always_comb begin
        state_d = state_q;
        ad_d    = ad_q;
        di_d    = di_q;
        we_d    = we_q;
        hit_d   = hit_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        do_d    = do_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ad_d    = HS_AD;
                    di_d    = HS_DI;
                    we_d    = HS_WE;
                    hit_d   = dec_hit;
                    sel_d   = dec_idx;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (we_q) begin
                    ack_d   = 1'b1;
                    err_d   = !hit_q;
                    state_d = StDone;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = StWaitRd;
                end
            end
            StWaitRd: begin
                if (cnt_q == 3'd0) begin
                    ack_d   = 1'b1;
                    err_d   = !hit_q;
                    do_d    = hit_q ? rd_sel : '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDone: begin
                // One acknowledge per request: wait for the requester to let go.
                if (!HS_REQ) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK40M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            ad_q    <= '0;
            di_q    <= '0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            ad_q    <= ad_d;
            di_q    <= di_d;
            we_q    <= we_d;
            hit_q   <= hit_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            do_q    <= do_d;
        end
    end

    // Region strobes: select through ISSUE and WAITRD, write only in ISSUE, none on a miss.
    always_comb begin
        RG_CS = '0;
        RG_WE = '0;
        if (hit_q && (state_q == StIssue || state_q == StWaitRd)) begin
            RG_CS[sel_q] = 1'b1;
        end
        if (hit_q && we_q && state_q == StIssue) begin
            RG_WE[sel_q] = 1'b1;
        end
    end

    assign HS_ACK = ack_q;
    assign HS_ERR = err_q;
    assign HS_DO  = do_q;
    assign RG_AD  = ad_q;
    assign RG_DI  = di_q;

endmodule

// File: tb/tb_hs_mem_bridge.sv
`timescale 1ns/1ps
// Bench for hs_mem_bridge: four behavioural region memories behind the bridge and a
// scoreboard of expected acknowledge results built from a shadow copy of the memories.
module tb_hs_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pause_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] ad = '0;
    logic [7:0]  di = '0;
    logic        hs_ack;
    logic [7:0]  hs_do;
    logic        hs_err;
    logic [3:0]  rg_cs;
    logic [3:0]  rg_we;
    logic [15:0] rg_ad;
    logic [7:0]  rg_di;
    logic [31:0] rg_do;

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } exp_t;

    exp_t       sb[$];
    exp_t       ex;
    logic [7:0] exp_mem [4][256];
    logic [7:0] mem [4][256];
    logic [7:0] last_rd = 8'h00;
    int         n_chk = 0;
    int         n_pass = 0;

    hs_mem_bridge #(
        .NREG(4), .AW(16), .DW(8), .SELW(4), .REG_TAG(16'hFEDC), .RD_LAT(3), .NEED_PAUSE(1'b1)
    ) dut (
        .CLK40M (clk),
        .RESET_N(rst_n),
        .PAUSE_N(pause_n),
        .HS_REQ (req),
        .HS_WE  (we),
        .HS_AD  (ad),
        .HS_DI  (di),
        .HS_ACK (hs_ack),
        .HS_DO  (hs_do),
        .HS_ERR (hs_err),
        .RG_CS  (rg_cs),
        .RG_WE  (rg_we),
        .RG_AD  (rg_ad),
        .RG_DI  (rg_di),
        .RG_DO  (rg_do)
    );

    always #12 clk = ~clk;

    // Region memories, indexed by the low address byte.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rg_we[i]) mem[i][rg_ad[7:0]] <= rg_di;
        end
    end

    always_comb begin
        rg_do = '0;
        for (int i = 0; i < 4; i++) rg_do[i*8+:8] = mem[i][rg_ad[7:0]];
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected result of one transaction, pushed before it is driven.
    task automatic push_exp(input logic w, input logic [15:0] a, input logic [7:0] d);
        logic hit;
        int   r;
        hit = (a[15:12] >= 4'hC);
        r   = int'(a[15:12]) - 12;
        if (w) begin
            if (hit) exp_mem[r][a[7:0]] = d;
            sb.push_back('{d: last_rd, e: !hit});
        end else begin
            last_rd = hit ? exp_mem[r][a[7:0]] : 8'h00;
            sb.push_back('{d: last_rd, e: !hit});
        end
    endtask

    // Drives one request from a negedge, scrambles the inputs after the start edge, holds
    // REQ for 'hold' cycles after the ack, then leaves REQ low for one clock edge.
    task automatic run_txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                           input int hold, output int lat, output int cs_n, output int we_n,
                           output logic [3:0] cs_or, output logic [3:0] we_or,
                           output logic [7:0] do_v, output logic err_v, output int ack_n,
                           output logic [15:0] rad, output logic [7:0] rdi);
        int after;
        lat = 0; cs_n = 0; we_n = 0; cs_or = '0; we_or = '0; do_v = '0; err_v = 1'b0;
        ack_n = 0; rad = '0; rdi = '0; after = -1;
        we = w; ad = a; di = d; req = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (rg_cs != 4'b0) cs_n++;
            if (rg_we != 4'b0) we_n++;
            cs_or = cs_or | rg_cs;
            we_or = we_or | rg_we;
            if (hs_ack) begin
                ack_n++;
                if (lat == 0) begin
                    lat = k; do_v = hs_do; err_v = hs_err; rad = rg_ad; rdi = rg_di;
                    after = 0;
                end
            end else if (after >= 0) begin
                after++;
            end
            if (k == 1) begin
                ad = ~a; di = ~d; we = ~w;
            end
            if (after == hold) req = 1'b0;
            if (after == hold + 1) break;
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if ({hs_ack, hs_do, hs_err, rg_cs, rg_we, rg_ad, rg_di} !== '0)
            $display("FAIL reset_outputs got %h want 0",
                     {hs_ack, hs_do, hs_err, rg_cs, rg_we, rg_ad, rg_di});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if ({hs_ack, rg_cs, rg_we} !== '0)
            $display("FAIL reset_idle got %h want 0", {hs_ack, rg_cs, rg_we});
        else n_pass++;
    endtask

    task automatic test_write();
        int lat, cs_n, we_n, ack_n;
        logic [3:0] cs_or, we_or;
        logic [7:0] do_v, rdi;
        logic err_v;
        logic [15:0] rad;
        push_exp(1'b1, 16'hC012, 8'h5A);
        run_txn(1'b1, 16'hC012, 8'h5A, 0, lat, cs_n, we_n, cs_or, we_or, do_v, err_v, ack_n,
                rad, rdi);
        ex = sb.pop_front();
        n_chk++; if (lat !== 2) $display("FAIL wr_latency got %0d want 2", lat); else n_pass++;
        n_chk++; if (cs_or !== 4'b0001 || cs_n !== 1)
            $display("FAIL wr_cs got %b/%0d want 0001/1", cs_or, cs_n); else n_pass++;
        n_chk++; if (we_or !== 4'b0001 || we_n !== 1)
            $display("FAIL wr_we got %b/%0d want 0001/1", we_or, we_n); else n_pass++;
        n_chk++; if (rad !== 16'hC012 || rdi !== 8'h5A)
            $display("FAIL wr_addr_data got %h/%h want c012/5a", rad, rdi); else n_pass++;
        n_chk++; if (err_v !== ex.e || do_v !== ex.d)
            $display("FAIL wr_ack got err %b do %h want err %b do %h", err_v, do_v, ex.e, ex.d);
        else n_pass++;
    endtask

    task automatic test_read();
        int lat, cs_n, we_n, ack_n;
        logic [3:0] cs_or, we_or;
        logic [7:0] do_v, rdi;
        logic err_v;
        logic [15:0] rad;
        logic [15:0] addrs [4] = '{16'hE100, 16'hE100, 16'hC012, 16'hD055};
        logic [7:0]  data  [4] = '{8'hA7, 8'h00, 8'h00, 8'h3C};
        logic        wes   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 4; t++) begin
            push_exp(wes[t], addrs[t], data[t]);
            run_txn(wes[t], addrs[t], data[t], 0, lat, cs_n, we_n, cs_or, we_or, do_v, err_v,
                    ack_n, rad, rdi);
            ex = sb.pop_front();
            n_chk++;
            if (lat !== (wes[t] ? 2 : 5))
                $display("FAIL rd_latency[%0d] got %0d want %0d", t, lat, wes[t] ? 2 : 5);
            else n_pass++;
            n_chk++;
            if (do_v !== ex.d || err_v !== ex.e)
                $display("FAIL rd_data[%0d] got %h/%b want %h/%b", t, do_v, err_v, ex.d, ex.e);
            else n_pass++;
            if (t == 1) begin
                n_chk++;
                if (cs_or !== 4'b0100 || cs_n !== 4 || we_n !== 0)
                    $display("FAIL rd_strobes got cs %b x%0d we x%0d want 0100 x4 we x0",
                             cs_or, cs_n, we_n);
                else n_pass++;
            end
        end
    endtask

    task automatic test_unmatched();
        int lat, cs_n, we_n, ack_n;
        logic [3:0] cs_or, we_or;
        logic [7:0] do_v, rdi;
        logic err_v;
        logic [15:0] rad;
        logic [15:0] addrs [2] = '{16'h1234, 16'h5678};
        logic        wes   [2] = '{1'b0, 1'b1};
        for (int t = 0; t < 2; t++) begin
            push_exp(wes[t], addrs[t], 8'hEE);
            run_txn(wes[t], addrs[t], 8'hEE, 0, lat, cs_n, we_n, cs_or, we_or, do_v, err_v,
                    ack_n, rad, rdi);
            ex = sb.pop_front();
            n_chk++;
            if (cs_n !== 0 || we_n !== 0)
                $display("FAIL miss_strobes[%0d] got cs x%0d we x%0d want 0", t, cs_n, we_n);
            else n_pass++;
            n_chk++;
            if (lat !== (wes[t] ? 2 : 5) || err_v !== ex.e || do_v !== ex.d)
                $display("FAIL miss_ack[%0d] got lat %0d err %b do %h want err %b do %h",
                         t, lat, err_v, do_v, ex.e, ex.d);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        int lat, cs_n, we_n, ack_n, busy;
        logic [3:0] cs_or, we_or;
        logic [7:0] do_v, rdi;
        logic err_v;
        logic [15:0] rad;
        push_exp(1'b1, 16'hF003, 8'hC3);
        run_txn(1'b1, 16'hF003, 8'hC3, 0, lat, cs_n, we_n, cs_or, we_or, do_v, err_v, ack_n,
                rad, rdi);
        ex = sb.pop_front();
        push_exp(1'b0, 16'hF003, 8'h00);
        pause_n = 1'b1; req = 1'b1; we = 1'b0; ad = 16'hF003;
        busy = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rg_cs != 4'b0 || hs_ack) busy++;
        end
        n_chk++; if (busy !== 0) $display("FAIL pause_gate got %0d busy want 0", busy);
        else n_pass++;
        pause_n = 1'b0;
        @(negedge clk);
        n_chk++; if (rg_cs !== 4'b1000) $display("FAIL pause_start got %b want 1000", rg_cs);
        else n_pass++;
        pause_n = 1'b1;
        lat = 0;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (hs_ack) begin
                lat = k; do_v = hs_do; err_v = hs_err;
                break;
            end
        end
        ex = sb.pop_front();
        n_chk++;
        if (lat !== 5 || do_v !== ex.d || err_v !== ex.e)
            $display("FAIL pause_complete got lat %0d do %h err %b want 5 %h %b",
                     lat, do_v, err_v, ex.d, ex.e);
        else n_pass++;
        req = 1'b0;
        @(negedge clk);
        pause_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, cs_n, we_n, ack_n, busy;
        logic [3:0] cs_or, we_or;
        logic [7:0] do_v, rdi;
        logic err_v;
        logic [15:0] rad;
        req = 1'b1; we = 1'b0; ad = 16'hE100;
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({hs_ack, hs_do, hs_err, rg_cs, rg_we, rg_ad, rg_di} !== '0)
            $display("FAIL reset_async got %h want 0",
                     {hs_ack, hs_do, hs_err, rg_cs, rg_we, rg_ad, rg_di});
        else n_pass++;
        last_rd = 8'h00;
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        busy = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rg_cs != 4'b0 || hs_ack) busy++;
        end
        n_chk++; if (busy !== 0) $display("FAIL reset_release got %0d busy want 0", busy);
        else n_pass++;
        push_exp(1'b0, 16'hE100, 8'h00);
        run_txn(1'b0, 16'hE100, 8'h00, 0, lat, cs_n, we_n, cs_or, we_or, do_v, err_v, ack_n,
                rad, rdi);
        ex = sb.pop_front();
        n_chk++;
        if (lat !== 5 || do_v !== ex.d)
            $display("FAIL reset_resume got lat %0d do %h want 5 %h", lat, do_v, ex.d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, cs_n, we_n, ack_n;
        logic [3:0] cs_or, we_or;
        logic [7:0] do_v, rdi;
        logic err_v;
        logic [15:0] rad;
        push_exp(1'b0, 16'hC012, 8'h00);
        run_txn(1'b0, 16'hC012, 8'h00, 10, lat, cs_n, we_n, cs_or, we_or, do_v, err_v, ack_n,
                rad, rdi);
        ex = sb.pop_front();
        n_chk++;
        if (ack_n !== 1 || we_n !== 0 || do_v !== ex.d)
            $display("FAIL held_req got acks %0d writes %0d do %h want 1 0 %h",
                     ack_n, we_n, do_v, ex.d);
        else n_pass++;
        push_exp(1'b1, 16'hD001, 8'h77);
        run_txn(1'b1, 16'hD001, 8'h77, 0, lat, cs_n, we_n, cs_or, we_or, do_v, err_v, ack_n,
                rad, rdi);
        ex = sb.pop_front();
        n_chk++;
        if (lat !== 2 || ack_n !== 1 || we_or !== 4'b0010 || do_v !== ex.d)
            $display("FAIL second_req got lat %0d acks %0d we %b do %h want 2 1 0010 %h",
                     lat, ack_n, we_or, do_v, ex.d);
        else n_pass++;
        push_exp(1'b0, 16'hD001, 8'h00);
        run_txn(1'b0, 16'hD001, 8'h00, 0, lat, cs_n, we_n, cs_or, we_or, do_v, err_v, ack_n,
                rad, rdi);
        ex = sb.pop_front();
        n_chk++;
        if (lat !== 5 || do_v !== ex.d)
            $display("FAIL readback got lat %0d do %h want 5 %h", lat, do_v, ex.d);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_unmatched();
        test_pause();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
